// File: rtl/keyboard_pkg.sv
// keyboard_pkg: shared character constants, UART framing and sequencer states for the key-code UART sender.
package keyboard_pkg;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_DONE} seq_state_e;

    function automatic int char_count(input int nbytes, input bit crlf);
        return nbytes * 2 + (crlf ? 2 : 0);
    endfunction
endpackage

// File: rtl/ascii_uart_sender_if.sv
// ascii_uart_sender_if: ASCII word, send strobe, status and serial line of the UART sender.
interface ascii_uart_sender_if #(parameter int NBYTES = 2);
    logic [NBYTES*16-1:0] ascii_in;
    logic send;
    logic busy;
    logic done;
    logic tx;

    modport master (output ascii_in, send, input busy, done, tx);
    modport slave (input ascii_in, send, output busy, done, tx);
endinterface

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 transmitter, DIV clocks per bit, tx_done on the last cycle of the stop bit.
module uart_tx_core
    import keyboard_pkg::*;
#(
    parameter int DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          bit_end, last_bit;

    assign bit_end  = baud_q == BW'(DIV - 1);
    assign last_bit = bit_q == 4'(UART_FRAME_BITS - 1);

    // Ones shift in behind the data so the stop bit falls out of the register naturally.
    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        if (!busy_q) begin
            if (start) begin
                busy_d  = 1'b1;
                baud_d  = '0;
                bit_d   = '0;
                shift_d = data;
                tx_d    = 1'b0;
            end
        end else if (bit_end) begin
            baud_d  = '0;
            bit_d   = last_bit ? 4'd0 : bit_q + 4'd1;
            tx_d    = last_bit ? 1'b1 : shift_q[0];
            shift_d = {1'b1, shift_q[7:1]};
            busy_d  = !last_bit;
        end else begin
            baud_d = baud_q + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = busy_q && bit_end && last_bit;
endmodule

// File: rtl/ascii_uart_sender.sv
// ascii_uart_sender: latches an ASCII word on send and transmits it MSB character first, optionally followed by CR/LF.
module ascii_uart_sender
    import keyboard_pkg::*;
#(
    parameter int NBYTES      = 2,
    parameter int CLK_HZ      = 100000000,
    parameter int BAUD        = 115200,
    parameter bit APPEND_CRLF = 1'b1
) (
    input logic clk,
    input logic rst_n,
    ascii_uart_sender_if.slave bus
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int N   = char_count(NBYTES, APPEND_CRLF);
    localparam int IW  = $clog2(N);

    seq_state_e            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NBYTES*16-1:0]  shadow_q, shadow_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [N*8-1:0]        str;
    logic [7:0]            cur_char;
    logic                  start, core_busy, tx_done;

    // Index 0 is the last character on the line, so CR/LF sit below the hex text.
    generate
        if (APPEND_CRLF) begin : g_crlf
            assign str = {shadow_q, CHAR_CR, CHAR_LF};
        end else begin : g_raw
            assign str = shadow_q;
        end
    endgenerate

    assign cur_char = str[{idx_q, 3'b000} +: 8];
    assign start    = (state_q == S_SEND) && !core_busy;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: if (bus.send) begin
                state_d  = S_LOAD;
                shadow_d = bus.ascii_in;
                idx_d    = IW'(N - 1);
                busy_d   = 1'b1;
            end
            S_LOAD: state_d = S_SEND;
            S_SEND: state_d = S_WAIT;
            S_WAIT: if (tx_done) begin
                state_d = (idx_q == '0) ? S_DONE : S_SEND;
                idx_d   = (idx_q == '0) ? idx_q : idx_q - IW'(1);
                done_d  = idx_q == '0;
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    uart_tx_core #(.DIV(DIV)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data    (cur_char),
        .tx      (bus.tx),
        .tx_busy (core_busy),
        .tx_done (tx_done)
    );

    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_ascii_uart_sender.sv
// tb_ascii_uart_sender: random and directed strings on a CR/LF and a bare instance, checked by a UART decoder scoreboard.
module tb_ascii_uart_sender;
    typedef struct {
        logic [7:0] b;
        int         rel;
        bit         last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ascii_uart_sender_if #(.NBYTES(2)) ia ();
    ascii_uart_sender_if #(.NBYTES(2)) ib ();

    ascii_uart_sender #(.NBYTES(2), .CLK_HZ(16), .BAUD(1), .APPEND_CRLF(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia));
    ascii_uart_sender #(.NBYTES(2), .CLK_HZ(16), .BAUD(1), .APPEND_CRLF(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_fail = 0, epoch = 0;
    exp_t qa[$], qb[$];
    int last_start[2], last_done[2], exp_done[2], got_done[2];
    bit end_seen[2];

    function automatic logic tx_of(input bit s);
        return s ? ib.tx : ia.tx;
    endfunction
    function automatic logic busy_of(input bit s);
        return s ? ib.busy : ia.busy;
    endfunction
    function automatic logic done_of(input bit s);
        return s ? ib.done : ia.done;
    endfunction
    function automatic logic [7:0] hexch(input int v);
        return v < 10 ? 8'(48 + v) : 8'(55 + v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference model: the hex text most significant character first, then CR, LF on instance a.
    task automatic push_string(input bit s, input logic [31:0] w, input int rel0);
        exp_t e;
        int n = s ? 4 : 6;
        for (int k = 0; k < n; k++) begin
            e.b    = k < 4 ? w[8*(3-k) +: 8] : (k == 4 ? 8'h0D : 8'h0A);
            e.rel  = k == 0 ? rel0 : 1;
            e.last = k == n - 1;
            if (s) qb.push_back(e);
            else qa.push_back(e);
        end
        exp_done[s]++;
    endtask

    task automatic decoder(input bit s);
        exp_t e;
        logic [7:0] d;
        logic sb, stp;
        int st, ep, qs;
        string p = s ? "b" : "a";
        forever begin
            @(negedge clk);
            if (rst_n && tx_of(s) === 1'b0) begin
                st = cyc;
                ep = epoch;
                repeat (8) @(negedge clk);
                sb = tx_of(s);
                for (int b = 0; b < 8; b++) begin
                    repeat (16) @(negedge clk);
                    d[b] = tx_of(s);
                end
                repeat (16) @(negedge clk);
                stp = tx_of(s);
                if (ep == epoch) begin
                    qs = s ? qb.size() : qa.size();
                    chk({p, "_frame_expected"}, 32'(qs > 0), 1);
                    if (qs > 0) begin
                        e = s ? qb.pop_front() : qa.pop_front();
                        chk({p, "_char"}, d, e.b);
                        chk({p, "_start_bit"}, sb, 0);
                        chk({p, "_stop_bit"}, stp, 1);
                        if (e.rel == 1) chk({p, "_frame_gap"}, st - last_start[s], 161);
                        if (e.rel == 2) chk({p, "_restart_gap"}, st - last_done[s], 4);
                        end_seen[s] = e.last;
                    end
                end
                last_start[s] = st;
            end
        end
    endtask

    task automatic done_mon(input bit s);
        string p = s ? "b" : "a";
        forever begin
            @(negedge clk);
            if (done_of(s) === 1'b1) begin
                got_done[s]++;
                chk({p, "_busy_at_done"}, busy_of(s), 1);
                chk({p, "_done_after_last"}, end_seen[s], 1);
                chk({p, "_done_timing"}, cyc - last_start[s], 160);
                end_seen[s]  = 0;
                last_done[s] = cyc;
            end
        end
    endtask

    task automatic send_str(input bit s, input logic [31:0] w);
        @(negedge clk);
        if (s) begin ib.ascii_in = w; ib.send = 1'b1; end
        else begin ia.ascii_in = w; ia.send = 1'b1; end
        push_string(s, w, 0);
        @(posedge clk);
        #1;
        if (s) ib.send = 1'b0;
        else ia.send = 1'b0;
        chk("busy_after_send", busy_of(s), 1);
        chk("tx_edge0", tx_of(s), 1);
        @(posedge clk);
        #1 chk("tx_edge1", tx_of(s), 1);
        @(posedge clk);
        #1 chk("tx_edge2_start", tx_of(s), 0);
    endtask

    task automatic wait_idle(input bit s);
        for (int i = 0; i < 2000 && busy_of(s); i++) @(negedge clk);
        chk("idle_in_time", busy_of(s), 0);
    endtask

    initial begin
        fork
            decoder(0);
            decoder(1);
            done_mon(0);
            done_mon(1);
        join_none
    end

    initial begin
        bit s;
        logic [31:0] w;
        ia.send = 0; ia.ascii_in = '0;
        ib.send = 0; ib.ascii_in = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_tx", tx_of(k[0]), 1);
            chk("rst_busy", busy_of(k[0]), 0);
            chk("rst_done", done_of(k[0]), 0);
        end
        rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("idle_tx", tx_of(k[0]), 1);
                chk("idle_busy", busy_of(k[0]), 0);
                chk("idle_done", done_of(k[0]), 0);
            end
        end

        send_str(0, 32'h31433241);
        repeat (221) @(negedge clk);
        ia.ascii_in = 32'h46464646;
        ia.send = 1'b1;
        @(negedge clk);
        ia.send = 1'b0;
        chk("busy_ignores_send", ia.busy, 1);
        wait_idle(0);

        send_str(1, 32'h30303041);
        wait_idle(1);

        send_str(0, 32'h35364142);
        repeat (392) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", ia.tx, 1);
        chk("abort_busy", ia.busy, 0);
        qa.delete();
        exp_done[0]--;
        epoch++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        send_str(0, 32'h35364142);
        wait_idle(0);

        @(negedge clk);
        ia.ascii_in = 32'h39384443;
        ia.send = 1'b1;
        push_string(0, 32'h39384443, 0);
        repeat (10) @(negedge clk);
        ia.ascii_in = 32'h45463031;
        push_string(0, 32'h45463031, 2);
        for (int i = 0; i < 2000 && ia.done !== 1'b1; i++) @(negedge clk);
        chk("held_first_done", ia.done, 1);
        repeat (2) @(negedge clk);
        ia.send = 1'b0;
        wait_idle(0);

        for (int r = 0; r < 6; r++) begin
            s = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) w[8*k +: 8] = hexch(int'($urandom_range(0, 15)));
            repeat ($urandom_range(1, 20)) @(negedge clk);
            send_str(s, w);
            wait_idle(s);
        end

        repeat (50) @(negedge clk);
        chk("a_done_count", got_done[0], exp_done[0]);
        chk("b_done_count", got_done[1], exp_done[1]);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
